maxnet_ctrl: RTL and testbench

- FSM controller that sequences the 4-input float32 Maxnet (winner-take-all) datapath.
- Loads the operands and issues one lateral-inhibition iteration at a time. Each iteration is handshaked against the datapath's completion strobe.
- Detects convergence from per-neuron nonzero flags and reports the winner index, a no-winner (tie) result, or a timeout.
- Sits between the top-level start/done interface and the Maxnet arithmetic core.

---
 rtl/maxnet_ctrl.sv | 136 +++++++++++++
 tb/tb_maxnet_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_ctrl.sv
// Sequencing controller for the Maxnet winner-take-all datapath: loads operands, issues
// handshaked inhibition iterations and reports winner, exact tie or iteration timeout.
module maxnet_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_ITER = 32,
    parameter int unsigned CNT_W    = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 dp_done,
    input  logic [N-1:0]         nz,
    output logic                 ld_inputs,
    output logic                 iter_en,
    output logic                 busy,
    output logic                 done,
    output logic [$clog2(N)-1:0] winner_idx,
    output logic [N-1:0]         winner_onehot,
    output logic                 no_winner,
    output logic                 timeout,
    output logic [CNT_W-1:0]     iter_count
);
    localparam int unsigned      IdxW   = $clog2(N);
    localparam logic [N-1:0]     One    = N'(1);
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {StIdle, StLoad, StCheck, StIter, StWait, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [N-1:0]    oh_q, oh_d;
    logic            nw_q, nw_d;
    logic            to_q, to_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            any_nz;
    logic            single_nz;
    logic [N-1:0]    low_oh;
    logic [IdxW-1:0] low_idx;

    // nz & (nz - 1) clears the lowest set bit; zero result means at most one bit was set.
    always_comb begin
        any_nz    = |nz;
        single_nz = any_nz && ((nz & (nz - One)) == '0);
        low_oh    = nz & ~(nz - One);
        low_idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (low_oh[i]) begin
                low_idx = IdxW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        nw_d    = nw_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    idx_d   = '0;
                    oh_d    = '0;
                    nw_d    = 1'b0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            StLoad: state_d = StCheck;
            StCheck: begin
                if (single_nz) begin
                    state_d = StDone;
                    idx_d   = low_idx;
                    oh_d    = nz;
                end else if (!any_nz) begin
                    state_d = StDone;
                    nw_d    = 1'b1;
                    idx_d   = '0;
                    oh_d    = '0;
                end else if (cnt_q == MaxCnt) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                    idx_d   = low_idx;
                    oh_d    = low_oh;
                end else begin
                    state_d = StIter;
                end
            end
            StIter: begin
                state_d = StWait;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWait: begin
                if (dp_done) begin
                    state_d = StCheck;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            oh_q    <= '0;
            nw_q    <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            nw_q    <= nw_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ld_inputs     = (state_q == StLoad);
    assign iter_en       = (state_q == StIter);
    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StDone);
    assign winner_idx    = idx_q;
    assign winner_onehot = oh_q;
    assign no_winner     = nw_q;
    assign timeout       = to_q;
    assign iter_count    = cnt_q;

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Directed bench for maxnet_ctrl with a small datapath model that replays an nz sequence
// and answers each iter_en with dp_done three cycles later.
module tb_maxnet_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       dp_done;
    logic [3:0] nz = 4'b0000;
    logic       ld_inputs, iter_en, busy, done, no_winner, timeout;
    logic [1:0] winner_idx;
    logic [3:0] winner_onehot;
    logic [5:0] iter_count;

    logic       dp_done_m = 1'b0;
    logic       dp_spur;
    logic [3:0] nz_seq [0:7];
    int         iter_pulses = 0;
    int         dp_timer = 0;
    int         total = 0;
    int         bad = 0;

    assign dp_done = dp_done_m | dp_spur;

    maxnet_ctrl #(.N(4), .MAX_ITER(4), .CNT_W(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dp_done       (dp_done),
        .nz            (nz),
        .ld_inputs     (ld_inputs),
        .iter_en       (iter_en),
        .busy          (busy),
        .done          (done),
        .winner_idx    (winner_idx),
        .winner_onehot (winner_onehot),
        .no_winner     (no_winner),
        .timeout       (timeout),
        .iter_count    (iter_count)
    );

    always #5 clk = ~clk;

    // Datapath model, driven on the falling edge.
    always @(negedge clk) begin
        dp_done_m = 1'b0;
        if (!busy) begin
            dp_timer = 0;
        end else begin
            if (ld_inputs) nz = nz_seq[0];
            if (iter_en) begin
                iter_pulses++;
                dp_timer = 3;
            end else if (dp_timer > 0) begin
                dp_timer--;
                if (dp_timer == 0) begin
                    dp_done_m = 1'b1;
                    nz = nz_seq[iter_pulses];
                end
            end
        end
    end

    task automatic set_seq(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] s3, input logic [3:0] s4);
        nz_seq[0] = s0; nz_seq[1] = s1; nz_seq[2] = s2; nz_seq[3] = s3; nz_seq[4] = s4;
        nz_seq[5] = s4; nz_seq[6] = s4; nz_seq[7] = s4;
    endtask

    // Leaves the caller on the falling edge inside the LOAD cycle (cycle E+1).
    task automatic do_start();
        @(negedge clk);
        iter_pulses = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = c0;
        for (int k = 0; k < 300; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; dp_spur = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ld_inputs, iter_en, busy, done, winner_idx, winner_onehot, no_winner, timeout,
             iter_count} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %0h want 0", {ld_inputs, iter_en, busy, done,
                     winner_idx, winner_onehot, no_winner, timeout, iter_count});
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; dp_spur = 1'b0;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_ignored: busy=%b want 0", busy); end
    endtask

    task automatic test_basic();
        int cyc; bit ok;
        set_seq(4'b1111, 4'b1111, 4'b0011, 4'b0001, 4'b0001);
        do_start();
        total++;
        if (ld_inputs !== 1'b1) begin bad++; $display("FAIL basic_load: ld_inputs=%b want 1", ld_inputs); end
        wait_done(1, cyc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL basic_done: no done within bound"); end
        total++;
        if (cyc !== 18) begin bad++; $display("FAIL basic_latency: got %0d want 18", cyc); end
        total++;
        if (iter_pulses !== 3) begin bad++; $display("FAIL basic_iters: got %0d want 3", iter_pulses); end
        total++;
        if ({winner_idx, winner_onehot, no_winner, timeout, iter_count} !== {2'd0, 4'b0001, 1'b0, 1'b0, 6'd3}) begin
            bad++;
            $display("FAIL basic_result: idx=%0d oh=%b nw=%b to=%b cnt=%0d want 0 0001 0 0 3",
                     winner_idx, winner_onehot, no_winner, timeout, iter_count);
        end
        @(negedge clk);
        total++;
        if ({done, busy, winner_idx, winner_onehot} !== {1'b0, 1'b0, 2'd0, 4'b0001}) begin
            bad++;
            $display("FAIL basic_hold: done=%b busy=%b idx=%0d oh=%b want 0 0 0 0001",
                     done, busy, winner_idx, winner_onehot);
        end
    endtask

    task automatic test_load_converged();
        int cyc; bit ok;
        set_seq(4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
        do_start();
        wait_done(1, cyc, ok);
        total++;
        if (!ok || cyc !== 3) begin bad++; $display("FAIL conv_latency: ok=%b cyc=%0d want 1 3", ok, cyc); end
        total++;
        if (iter_pulses !== 0) begin bad++; $display("FAIL conv_iters: got %0d want 0", iter_pulses); end
        total++;
        if ({winner_idx, winner_onehot, iter_count} !== {2'd2, 4'b0100, 6'd0}) begin
            bad++;
            $display("FAIL conv_result: idx=%0d oh=%b cnt=%0d want 2 0100 0",
                     winner_idx, winner_onehot, iter_count);
        end
    endtask

    task automatic test_tie();
        int cyc; bit ok;
        set_seq(4'b1100, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
        do_start();
        wait_done(1, cyc, ok);
        total++;
        if (!ok || cyc !== 13) begin bad++; $display("FAIL tie_latency: ok=%b cyc=%0d want 1 13", ok, cyc); end
        total++;
        if (iter_pulses !== 2) begin bad++; $display("FAIL tie_iters: got %0d want 2", iter_pulses); end
        total++;
        if ({no_winner, timeout, winner_idx, winner_onehot, iter_count} !== {1'b1, 1'b0, 2'd0, 4'b0000, 6'd2}) begin
            bad++;
            $display("FAIL tie_result: nw=%b to=%b idx=%0d oh=%b cnt=%0d want 1 0 0 0000 2",
                     no_winner, timeout, winner_idx, winner_onehot, iter_count);
        end
    endtask

    task automatic test_timeout();
        int cyc; bit ok;
        set_seq(4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0110);
        do_start();
        wait_done(1, cyc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timeout_done: no done within bound"); end
        total++;
        if (iter_pulses !== 4) begin bad++; $display("FAIL timeout_iters: got %0d want 4", iter_pulses); end
        total++;
        if ({timeout, no_winner, winner_idx, winner_onehot, iter_count} !== {1'b1, 1'b0, 2'd1, 4'b0010, 6'd4}) begin
            bad++;
            $display("FAIL timeout_result: to=%b nw=%b idx=%0d oh=%b cnt=%0d want 1 0 1 0010 4",
                     timeout, no_winner, winner_idx, winner_onehot, iter_count);
        end
    endtask

    task automatic test_ignore();
        int cyc; bit ok;
        set_seq(4'b1111, 4'b1111, 4'b0011, 4'b0001, 4'b0001);
        @(negedge clk);
        dp_spur = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ign_idle_done: busy=%b want 0", busy); end
        iter_pulses = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (ld_inputs !== 1'b1) begin bad++; $display("FAIL ign_load: ld_inputs=%b want 1", ld_inputs); end
        @(negedge clk);
        dp_spur = 1'b0;
        @(negedge clk);
        total++;
        if (iter_en !== 1'b1) begin bad++; $display("FAIL ign_first_iter: iter_en=%b want 1", iter_en); end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, cyc, ok);
        total++;
        if (!ok || cyc !== 18) begin bad++; $display("FAIL ign_latency: ok=%b cyc=%0d want 1 18", ok, cyc); end
        total++;
        if (iter_pulses !== 3) begin bad++; $display("FAIL ign_iters: got %0d want 3", iter_pulses); end
        total++;
        if ({winner_idx, winner_onehot, no_winner, timeout, iter_count} !== {2'd0, 4'b0001, 1'b0, 1'b0, 6'd3}) begin
            bad++;
            $display("FAIL ign_result: idx=%0d oh=%b nw=%b to=%b cnt=%0d want 0 0001 0 0 3",
                     winner_idx, winner_onehot, no_winner, timeout, iter_count);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ign_no_restart: busy=%b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        int cyc; bit ok; int seen;
        set_seq(4'b1111, 4'b1111, 4'b0011, 4'b0001, 4'b0001);
        do_start();
        seen = 0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            @(negedge clk);
            if (iter_en) seen++;
        end
        total++;
        if (seen !== 2) begin bad++; $display("FAIL mid_reach_iter2: saw %0d iter_en want 2", seen); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({ld_inputs, iter_en, busy, done, winner_idx, winner_onehot, no_winner, timeout,
             iter_count} !== 18'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %0h want 0", {ld_inputs, iter_en, busy, done,
                     winner_idx, winner_onehot, no_winner, timeout, iter_count});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_stay_idle: busy=%b want 0", busy); end
        do_start();
        wait_done(1, cyc, ok);
        total++;
        if (!ok || cyc !== 18) begin bad++; $display("FAIL mid_rerun_latency: ok=%b cyc=%0d want 1 18", ok, cyc); end
        total++;
        if (iter_pulses !== 3 || {winner_idx, winner_onehot, iter_count} !== {2'd0, 4'b0001, 6'd3}) begin
            bad++;
            $display("FAIL mid_rerun_result: iters=%0d idx=%0d oh=%b cnt=%0d want 3 0 0001 3",
                     iter_pulses, winner_idx, winner_onehot, iter_count);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dp_spur = 1'b0;
        set_seq(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        test_reset();
        test_basic();
        test_load_converged();
        test_tie();
        test_timeout();
        test_ignore();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
